// File: rtl/rw_manager_m10_ac_fetch.sv
// rtl/rw_manager_m10_ac_fetch.sv - AC ROM run fetcher with credit-based skid buffer and DDR3 AC decode
module rw_manager_m10_ac_fetch #(
    parameter int ROM_LATENCY = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  start_addr,
    input  logic [6:0]  word_count,
    output logic        busy,
    output logic        done,
    output logic [5:0]  rom_rdaddress,
    input  logic [31:0] rom_q,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [12:0] ac_addr,
    output logic [2:0]  ac_ba,
    output logic        ac_cs_n,
    output logic        ac_ras_n,
    output logic        ac_cas_n,
    output logic        ac_we_n,
    output logic        ac_odt,
    output logic        ac_cke,
    output logic        ac_reset_n
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                 state, state_next;
    logic [5:0]             addr, addr_hold;
    logic [6:0]             remaining_issue, remaining_accept;
    logic [ROM_LATENCY-1:0] tags;
    logic [31:0]            buffer [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          occupancy;
    logic [CW:0]            in_flight;
    logic                   credit_ok, issue, push, pop, done_r;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Reads already issued to the ROM hold a buffer slot, so the buffer can never overflow.
    always_comb begin
        in_flight = '0;
        for (int i = 0; i < ROM_LATENCY; i++)
            in_flight = in_flight + {{CW{1'b0}}, tags[i]};
    end

    assign credit_ok     = ({1'b0, occupancy} + in_flight) < (CW+1)'(FIFO_DEPTH);
    assign issue         = (state == FETCH) && (remaining_issue != 7'd0) && credit_ok;
    assign push          = tags[ROM_LATENCY-1];
    assign out_valid     = (occupancy != '0);
    assign pop           = out_valid && out_ready;
    assign busy          = (state != IDLE);
    assign done          = done_r;
    // Address is presented in the issue cycle itself so the ROM latency lines up with the tag pipe.
    assign rom_rdaddress = issue ? addr : addr_hold;
    assign out_word      = out_valid ? buffer[rd_ptr] : 32'd0;

    assign ac_addr    = out_word[12:0];
    assign ac_ba      = out_word[15:13];
    assign ac_cs_n    = out_word[16];
    assign ac_ras_n   = out_word[17];
    assign ac_cas_n   = out_word[18];
    assign ac_we_n    = out_word[19];
    assign ac_odt     = out_word[20];
    assign ac_cke     = out_word[26];
    assign ac_reset_n = out_word[27];

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start && word_count != 7'd0) state_next = FETCH;
            FETCH:   if (issue && remaining_issue == 7'd1) state_next = DRAIN;
            DRAIN:   if (pop && remaining_accept == 7'd1) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            addr             <= '0;
            addr_hold        <= '0;
            remaining_issue  <= '0;
            remaining_accept <= '0;
            tags             <= '0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            occupancy        <= '0;
            done_r           <= 1'b0;
        end else begin
            state  <= state_next;
            done_r <= ((state == IDLE) && start && (word_count == 7'd0)) ||
                      ((state == DRAIN) && pop && (remaining_accept == 7'd1));
            if ((state == IDLE) && start && (word_count != 7'd0)) begin
                addr             <= start_addr;
                remaining_issue  <= word_count;
                remaining_accept <= word_count;
            end
            if (issue) begin
                addr            <= addr + 6'd1;
                addr_hold       <= addr;
                remaining_issue <= remaining_issue - 7'd1;
            end
            if ((state != IDLE) && pop && (remaining_accept != 7'd0))
                remaining_accept <= remaining_accept - 7'd1;
            tags <= (tags << 1) | ROM_LATENCY'(issue);
            if (push) begin
                buffer[wr_ptr] <= rom_q;
                wr_ptr         <= ptr_inc(wr_ptr);
            end
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)
                occupancy <= occupancy + CW'(1);
            else if (pop && !push)
                occupancy <= occupancy - CW'(1);
        end
    end
endmodule

// File: tb/tb_rw_manager_m10_ac_fetch.sv
// tb/tb_rw_manager_m10_ac_fetch.sv - scoreboard bench for rw_manager_m10_ac_fetch with a 2-clock ROM model
module tb_rw_manager_m10_ac_fetch;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  start_addr = '0;
    logic [6:0]  word_count = '0;
    logic        busy, done, out_valid, out_ready = 1'b1;
    logic [5:0]  rom_rdaddress;
    logic [31:0] rom_q = '0, out_word;
    logic [12:0] ac_addr;
    logic [2:0]  ac_ba;
    logic        ac_cs_n, ac_ras_n, ac_cas_n, ac_we_n, ac_odt, ac_cke, ac_reset_n;

    rw_manager_m10_ac_fetch dut (
        .clock(clock), .reset(reset), .start(start), .start_addr(start_addr),
        .word_count(word_count), .busy(busy), .done(done), .rom_rdaddress(rom_rdaddress),
        .rom_q(rom_q), .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .ac_addr(ac_addr), .ac_ba(ac_ba), .ac_cs_n(ac_cs_n), .ac_ras_n(ac_ras_n),
        .ac_cas_n(ac_cas_n), .ac_we_n(ac_we_n), .ac_odt(ac_odt), .ac_cke(ac_cke),
        .ac_reset_n(ac_reset_n)
    );

    always #5 clock = ~clock;

    logic [31:0] rom [64];
    logic [5:0]  rom_a1 = '0;
    always @(posedge clock) begin
        rom_a1 <= rom_rdaddress;
        rom_q  <= rom[rom_a1];
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    logic [31:0] exp_q [$];
    logic [5:0]  addr_log [$];
    bit   log_en = 0;
    logic [5:0]  last_rd = '0;
    int   done_seen = 0, done_cyc = -1, first_valid_cyc = -1, first_acc_cyc = -1, last_acc_cyc = -1;
    int   start_cyc = 0;
    bit   busy_seen = 0, valid_seen = 0;
    logic [31:0] first_word = '0;
    logic [12:0] first_ac_addr = '0;
    logic [2:0]  first_ac_ba = '0;
    logic        first_cs_n = 0, first_cke = 0, first_reset_n = 0;

    always @(negedge clock) begin
        if (!reset) begin
            if (busy) busy_seen = 1;
            if (out_valid) begin
                valid_seen = 1;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (log_en && rom_rdaddress != last_rd) addr_log.push_back(rom_rdaddress);
            last_rd = rom_rdaddress;
            if (out_valid && out_ready) begin
                logic [31:0] w;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word got %h required none", out_word);
                end else begin
                    w = exp_q.pop_front();
                    if (out_word !== w) begin
                        errors++;
                        $display("FAIL out_word got %h required %h", out_word, w);
                    end
                    checks++;
                    if ({ac_reset_n, ac_cke, ac_odt, ac_we_n, ac_cas_n, ac_ras_n, ac_cs_n, ac_ba, ac_addr} !==
                        {w[27], w[26], w[20], w[19], w[18], w[17], w[16], w[15:13], w[12:0]}) begin
                        errors++;
                        $display("FAIL ac_decode got %h required word %h", {ac_reset_n, ac_cke, ac_odt, ac_we_n,
                                 ac_cas_n, ac_ras_n, ac_cs_n, ac_ba, ac_addr}, w);
                    end
                end
                if (first_acc_cyc < 0) begin
                    first_acc_cyc = cyc;
                    first_word = out_word;
                    first_ac_addr = ac_addr; first_ac_ba = ac_ba;
                    first_cs_n = ac_cs_n; first_cke = ac_cke; first_reset_n = ac_reset_n;
                end
                last_acc_cyc = cyc;
            end
            if (done) begin
                done_seen++;
                done_cyc = cyc;
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0h required %0h", name, got, want);
        end
    endtask

    // mode 0: always ready, 1: random ready, 2: ready low for cycles 4..10 after start
    task automatic run(input logic [5:0] a, input int n, input int mode, input bit spurious);
        int base_done, budget, rel;
        for (int i = 0; i < n; i++) exp_q.push_back(rom[(int'(a) + i) % 64]);
        base_done = done_seen;
        first_valid_cyc = -1; first_acc_cyc = -1; last_acc_cyc = -1;
        busy_seen = 0; valid_seen = 0;
        start_addr = a;
        word_count = 7'(n);
        start = 1'b1;
        start_cyc = cyc + 1;
        out_ready = 1'b1;
        tick;
        start = 1'b0;
        budget = 0;
        while (done_seen == base_done && budget < 3000) begin
            rel = cyc + 1 - start_cyc;
            case (mode)
                1:       out_ready = 1'($urandom_range(0, 1));
                2:       out_ready = !(rel >= 4 && rel <= 10);
                default: out_ready = 1'b1;
            endcase
            if (spurious && busy && $urandom_range(0, 3) == 0) begin
                start = 1'b1;
                start_addr = 6'($urandom);
                word_count = 7'($urandom_range(0, 64));
            end else begin
                start = 1'b0;
            end
            tick;
            budget++;
        end
        start = 1'b0;
        out_ready = 1'b1;
        check("done_timeout", budget < 3000, 1);
        @(negedge clock);
        check("busy_after_done", busy, 0);
        check("words_left", exp_q.size(), 0);
        exp_q.delete();
        repeat (3) tick;
        check("done_count", done_seen - base_done, 1);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = $urandom;
        rom[2] = 32'h0C010231;
        rom[3] = 32'h0C010330;
        rom[4] = 32'h0C012046;

        repeat (3) tick;
        @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", out_valid, 0);
        check("rst_rdaddr", rom_rdaddress, 0);
        check("rst_word", out_word, 0);
        check("rst_cs_n", ac_cs_n, 0);
        tick;
        reset = 1'b0;
        tick;

        run(6'h02, 3, 0, 0);
        check("first_latency", first_valid_cyc - start_cyc, 3);
        check("first_accept", first_acc_cyc - start_cyc, 3);
        check("burst_span", last_acc_cyc - first_acc_cyc, 2);
        check("done_latency", done_cyc - last_acc_cyc, 1);
        check("dec_word", first_word, 32'h0C010231);
        check("dec_addr", first_ac_addr, 13'h0231);
        check("dec_ba", first_ac_ba, 0);
        check("dec_cs_n", first_cs_n, 1);
        check("dec_cke", first_cke, 1);
        check("dec_reset_n", first_reset_n, 1);

        addr_log.delete();
        log_en = 1;
        run(6'h3E, 4, 0, 0);
        log_en = 0;
        check("wrap_len", addr_log.size(), 4);
        if (addr_log.size() == 4)
            check("wrap_seq", {addr_log[0], addr_log[1], addr_log[2], addr_log[3]}, 24'hFBF001);

        run(6'h10, 8, 2, 0);

        run(6'h07, 0, 0, 0);
        check("zero_done_next", done_cyc - start_cyc, 0);
        check("zero_busy", busy_seen, 0);
        check("zero_valid", valid_seen, 0);

        begin
            int base_done;
            base_done = done_seen;
            out_ready = 1'b0;
            start_addr = 6'h05; word_count = 7'd10; start = 1'b1;
            tick;
            start = 1'b0;
            tick;
            tick;
            reset = 1'b1;
            tick;
            reset = 1'b0;
            @(negedge clock);
            check("mid_rst_valid", out_valid, 0);
            check("mid_rst_busy", busy, 0);
            valid_seen = 0;
            out_ready = 1'b1;
            repeat (8) tick;
            check("mid_rst_no_valid", valid_seen, 0);
            check("mid_rst_no_done", done_seen - base_done, 0);
        end
        run(6'h00, 1, 0, 0);

        run(6'($urandom), 64, 1, 1);
        for (int r = 0; r < 12; r++)
            run(6'($urandom), $urandom_range(1, 64), $urandom_range(0, 1), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running required finished");
        $fatal(1);
    end
endmodule

// File: doc/rw_manager_m10_ac_fetch.md
Name: rw_manager_m10_ac_fetch

Overview:
- Consumer side of the address/command (AC) ROM interface of the RW manager.
- On a start request it streams a run of consecutive 32-bit AC words out of the synchronous AC ROM, which has 2 clocks of read latency and no enable.
- Presents the words on a valid/ready stream with a skid buffer, so back-pressure never loses a word already in flight.
- Also provides a combinational decode of the head word into DDR3 command/address fields for the PHY AC path.

Parameters:
- ROM_LATENCY, 2, clocks from rom_rdaddress change to matching rom_q; supported range 1..3.
- FIFO_DEPTH, 4, skid buffer entries; must be ≥ ROM_LATENCY+1.

Ports:
- clock  in  1  single clock for all logic
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request; sampled only when busy=0
- start_addr  in  6  first ROM address of the run
- word_count  in  7  number of words, 0..64
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the last word is accepted by the sink
- rom_rdaddress  out  6  address to the AC ROM
- rom_q  in  32  AC ROM data
- out_valid  out  1  head word available
- out_ready  in  1  sink accepts the word when out_valid & out_ready
- out_word  out  32  head word, raw
- ac_addr  out  13  out_word[12:0]
- ac_ba  out  3  out_word[15:13]
- ac_cs_n, ac_ras_n, ac_cas_n, ac_we_n  out  1 each  out_word[16], [17], [18], [19]
- ac_odt  out  1  out_word[20]
- ac_cke  out  1  out_word[26]
- ac_reset_n  out  1  out_word[27]

Behaviour:
- Reset values: busy=0, done=0, out_valid=0, rom_rdaddress=0, buffer empty, all in-flight tags cleared.
- out_word is 0 when the buffer is empty. The ac_* outputs are a pure combinational slice of out_word, so after reset ac_cs_n=0; the sink must qualify them with out_valid.
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE: start=1 with word_count≠0 latches addr=start_addr, remaining_issue=word_count, remaining_accept=word_count, and moves to FETCH.
  - IDLE: start=1 with word_count=0 gives done=1 on the next cycle, busy stays 0, and no ROM reads are issued.
- FETCH issue rule: each cycle where remaining_issue>0 and (occupancy + in_flight) < FIFO_DEPTH:
  - drive rom_rdaddress=addr and set the entry tag in a ROM_LATENCY-stage valid shift register;
  - then addr=addr+1 modulo 64 (0x3F wraps to 0x00), remaining_issue−1.
  - If the issue rule is not met, rom_rdaddress holds and no tag is set.
- Capture: a tag exiting the shift register writes rom_q into the buffer tail in that same cycle. The credit rule guarantees no overflow.
- Latency: with out_ready=1 throughout, the first out_valid occurs ROM_LATENCY+1 clocks after the accepted start. Sustained throughput is 1 word/clock.
- When remaining_issue reaches 0, FETCH moves to DRAIN.
- DRAIN: the cycle in which remaining_accept goes from 1 to 0 on an accept asserts done on the next clock and returns to IDLE; busy falls with done.
- Buffer: FIFO, in order. A push and a pop in the same cycle leave occupancy unchanged. out_valid=1 iff occupancy>0.
- Run lengths: 64 words from any start_addr read every ROM address exactly once, wrapping.
- start while busy=1 is ignored, with no effect on the current run.
- Reset mid-run: next cycle is IDLE; buffer and tags are flushed; later ROM data from pre-reset reads is discarded; no done.

Test Plan:
- ROM model with [0x02]=0x0C010231, [0x03]=0x0C010330, [0x04]=0x0C012046. start, addr 0x02, count 3, out_ready=1 → out_word 0x0C010231, 0x0C010330, 0x0C012046 on 3 consecutive cycles starting 3 clocks after start; done 1 clock after the last accept. First word decodes to ac_addr=0x0231, ac_ba=0, ac_cs_n=1, ac_cke=1, ac_reset_n=1.
- Wrap: start_addr 0x3E, count 4 → rom_rdaddress sequence 0x3E, 0x3F, 0x00, 0x01; outputs in that order.
- Back-pressure: count 8, out_ready low for cycles 4–10 → at most FIFO_DEPTH reads outstanding, no word lost or duplicated, all 8 delivered in order.
- word_count 0 → done pulse the next cycle, busy never asserted, no out_valid.
- Reset asserted 2 cycles into a count-10 run → out_valid=0 and busy=0 the next cycle; a new start (addr 0x00, count 1) returns only [0x00].
- start pulses during an active run → ignored; exactly word_count words and one done.
